// File: rtl/datapath_pkg.sv
// Shared datapath definitions: word/specifier widths and the control bundle
// carried from ID to EX.
package datapath_pkg;

    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int ALUOP_W = 4;

    // Control bits that travel with an instruction into EX
    typedef struct packed {
        logic               reg_write;
        logic               mem_to_reg;
        logic               mem_read;
        logic               mem_write;
        logic               alu_src;
        logic               reg_dst;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    // A bubble carries no side effects: every control bit is zero
    localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/wb_bypass_sel.sv
// Same-cycle write-back bypass for one register-file read port. Register 0 is
// hardwired to zero in the register file, so a write to it is never forwarded.
module wb_bypass_sel #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rf_spec,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] sel_data
);

    logic hit;

    // Forward WB data when WB writes the same non-zero register being read
    always_comb begin
        hit      = wb_we && (wb_reg != '0) && (wb_reg == rf_spec);
        sel_data = hit ? wb_data : rf_data;
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register. Captures one decoded instruction per cycle, with
// load-use stall (hold), branch flush (bubble), WB-to-ID bypass on capture and
// a saturating count of bubbles sent to EX. All outputs come straight from
// flops so the EX ALU-source mux sees stable inputs for the whole cycle.
module id_ex_stage_reg
    import datapath_pkg::*;
#(
    parameter int DATA_W  = datapath_pkg::DATA_W,
    parameter int REG_AW  = datapath_pkg::REG_AW,
    parameter int ALUOP_W = datapath_pkg::ALUOP_W,
    parameter int CNT_W   = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Stall,
    input  logic               Flush,
    input  logic               ID_Valid,
    input  logic [DATA_W-1:0]  ID_PCPlus4,
    input  logic [DATA_W-1:0]  ID_ReadData1,
    input  logic [DATA_W-1:0]  ID_ReadData2,
    input  logic [DATA_W-1:0]  ID_SignExtImm,
    input  logic [REG_AW-1:0]  ID_Rs,
    input  logic [REG_AW-1:0]  ID_Rt,
    input  logic [REG_AW-1:0]  ID_Rd,
    input  logic               ID_RegWrite,
    input  logic               ID_MemToReg,
    input  logic               ID_MemRead,
    input  logic               ID_MemWrite,
    input  logic               ID_ALUSrc,
    input  logic               ID_RegDst,
    input  logic [ALUOP_W-1:0] ID_ALUOp,
    input  logic               WB_RegWrite,
    input  logic [REG_AW-1:0]  WB_WriteReg,
    input  logic [DATA_W-1:0]  WB_WriteData,
    output logic               EX_Valid,
    output logic [DATA_W-1:0]  EX_PCPlus4,
    output logic [DATA_W-1:0]  EX_ReadData1,
    output logic [DATA_W-1:0]  EX_ReadData2,
    output logic [DATA_W-1:0]  EX_SignExtImm,
    output logic [REG_AW-1:0]  EX_Rs,
    output logic [REG_AW-1:0]  EX_Rt,
    output logic [REG_AW-1:0]  EX_Rd,
    output logic               EX_RegWrite,
    output logic               EX_MemToReg,
    output logic               EX_MemRead,
    output logic               EX_MemWrite,
    output logic               EX_ALUSrc,
    output logic               EX_RegDst,
    output logic [ALUOP_W-1:0] EX_ALUOp,
    output logic [CNT_W-1:0]   BubbleCount
);

    // Profiling counter sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic               valid_d,  valid_q;
    logic [DATA_W-1:0]  pc_d,     pc_q;
    logic [DATA_W-1:0]  rd1_d,    rd1_q;
    logic [DATA_W-1:0]  rd2_d,    rd2_q;
    logic [DATA_W-1:0]  imm_d,    imm_q;
    logic [REG_AW-1:0]  rs_d,     rs_q;
    logic [REG_AW-1:0]  rt_d,     rt_q;
    logic [REG_AW-1:0]  rd_d,     rd_q;
    ctrl_t              ctrl_d,   ctrl_q;
    logic [CNT_W-1:0]   bubble_d, bubble_q;

    ctrl_t              id_ctrl;
    logic [DATA_W-1:0]  rd1_fwd;
    logic [DATA_W-1:0]  rd2_fwd;

    wb_bypass_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_bypass_rs (
        .rf_spec  (ID_Rs),
        .rf_data  (ID_ReadData1),
        .wb_we    (WB_RegWrite),
        .wb_reg   (WB_WriteReg),
        .wb_data  (WB_WriteData),
        .sel_data (rd1_fwd)
    );

    wb_bypass_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_bypass_rt (
        .rf_spec  (ID_Rt),
        .rf_data  (ID_ReadData2),
        .wb_we    (WB_RegWrite),
        .wb_reg   (WB_WriteReg),
        .wb_data  (WB_WriteData),
        .sel_data (rd2_fwd)
    );

    // Gather the ID control bits into one bundle
    always_comb begin
        id_ctrl            = BUBBLE_CTRL;
        id_ctrl.reg_write  = ID_RegWrite;
        id_ctrl.mem_to_reg = ID_MemToReg;
        id_ctrl.mem_read   = ID_MemRead;
        id_ctrl.mem_write  = ID_MemWrite;
        id_ctrl.alu_src    = ID_ALUSrc;
        id_ctrl.reg_dst    = ID_RegDst;
        id_ctrl.alu_op     = ID_ALUOp;
    end

    // Next-state selection: Flush beats Stall, Stall holds, otherwise capture
    always_comb begin
        valid_d  = valid_q;
        pc_d     = pc_q;
        rd1_d    = rd1_q;
        rd2_d    = rd2_q;
        imm_d    = imm_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        rd_d     = rd_q;
        ctrl_d   = ctrl_q;
        bubble_d = bubble_q;
        if (Flush) begin
            valid_d  = 1'b0;
            pc_d     = '0;
            rd1_d    = '0;
            rd2_d    = '0;
            imm_d    = '0;
            rs_d     = '0;
            rt_d     = '0;
            rd_d     = '0;
            ctrl_d   = BUBBLE_CTRL;
            bubble_d = sat_inc(bubble_q);
        end else if (!Stall) begin
            valid_d = ID_Valid;
            pc_d    = ID_PCPlus4;
            rd1_d   = rd1_fwd;
            rd2_d   = rd2_fwd;
            imm_d   = ID_SignExtImm;
            rs_d    = ID_Rs;
            rt_d    = ID_Rt;
            rd_d    = ID_Rd;
            ctrl_d  = id_ctrl;
            if (!ID_Valid) begin
                ctrl_d   = BUBBLE_CTRL;
                bubble_d = sat_inc(bubble_q);
            end
        end
    end

    // Stage register with synchronous active-low clear
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            rd1_q    <= '0;
            rd2_q    <= '0;
            imm_q    <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            ctrl_q   <= BUBBLE_CTRL;
            bubble_q <= '0;
        end else begin
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            rd1_q    <= rd1_d;
            rd2_q    <= rd2_d;
            imm_q    <= imm_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            ctrl_q   <= ctrl_d;
            bubble_q <= bubble_d;
        end
    end

    assign EX_Valid      = valid_q;
    assign EX_PCPlus4    = pc_q;
    assign EX_ReadData1  = rd1_q;
    assign EX_ReadData2  = rd2_q;
    assign EX_SignExtImm = imm_q;
    assign EX_Rs         = rs_q;
    assign EX_Rt         = rt_q;
    assign EX_Rd         = rd_q;
    assign EX_RegWrite   = ctrl_q.reg_write;
    assign EX_MemToReg   = ctrl_q.mem_to_reg;
    assign EX_MemRead    = ctrl_q.mem_read;
    assign EX_MemWrite   = ctrl_q.mem_write;
    assign EX_ALUSrc     = ctrl_q.alu_src;
    assign EX_RegDst     = ctrl_q.reg_dst;
    assign EX_ALUOp      = ctrl_q.alu_op;
    assign BubbleCount   = bubble_q;

endmodule
